// File: rtl/cv32e41s_rvfi_pkg.sv
// rtl/cv32e41s_rvfi_pkg.sv - shared types and lane helpers for RVFI data OBI response tracking
package cv32e41s_rvfi_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } rvfi_obi_trans_t;

    // Rotate right by whole bytes: duplicate the word so shifted-out lanes wrap around.
    function automatic logic [31:0] obi_ror32(input logic [31:0] data, input logic [1:0] off);
        logic [63:0] dbl;
        dbl = {data, data} >> {off, 3'b000};
        return dbl[31:0];
    endfunction

    function automatic logic [31:0] obi_be_expand(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/cv32e41s_rvfi_obi_fifo.sv
// rtl/cv32e41s_rvfi_obi_fifo.sv - in-order tracker of granted OBI requests awaiting rvalid
module cv32e41s_rvfi_obi_fifo
    import cv32e41s_rvfi_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_i,
    input  rvfi_obi_trans_t                push_data_i,
    input  logic                           pop_i,
    output rvfi_obi_trans_t                pop_data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    rvfi_obi_trans_t mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
        end
        if (pop_i) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= push_data_i;
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Read is combinational from the pre-edge array, so a same-cycle push never aliases the pop.
    assign pop_data_o = mem_q[rptr_q];
    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/cv32e41s_rvfi_data_obi_resp.sv
// rtl/cv32e41s_rvfi_data_obi_resp.sv - pairs data OBI grants with responses and emits aligned records
module cv32e41s_rvfi_data_obi_resp
    import cv32e41s_rvfi_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           obi_req_i,
    input  logic                           obi_gnt_i,
    input  logic [31:0]                    obi_addr_i,
    input  logic                           obi_we_i,
    input  logic [3:0]                     obi_be_i,
    input  logic [31:0]                    obi_wdata_i,
    input  logic                           obi_rvalid_i,
    input  logic [31:0]                    obi_rdata_i,
    input  logic                           obi_err_i,
    output logic                           resp_valid_o,
    output logic [31:0]                    resp_addr_o,
    output logic                           resp_we_o,
    output logic [3:0]                     resp_be_o,
    output logic [31:0]                    resp_rdata_o,
    output logic [31:0]                    resp_wdata_o,
    output logic                           resp_err_o,
    output logic [$clog2(DEPTH+1)-1:0]     outstanding_o,
    output logic                           protocol_err_o
);

    rvfi_obi_trans_t push_data;
    rvfi_obi_trans_t pop_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            granted;
    logic            do_push;
    logic            do_pop;
    logic            violation;

    logic [1:0]  off;
    logic [3:0]  be_al;
    logic [31:0] rdata_al;
    logic [31:0] wdata_al;

    logic        resp_valid_q;
    logic [31:0] resp_addr_q,  resp_addr_d;
    logic        resp_we_q,    resp_we_d;
    logic [3:0]  resp_be_q,    resp_be_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] resp_wdata_q, resp_wdata_d;
    logic        resp_err_q,   resp_err_d;
    logic        protocol_err_q;

    assign push_data = '{addr: obi_addr_i, we: obi_we_i, be: obi_be_i, wdata: obi_wdata_i};
    assign granted   = obi_req_i && obi_gnt_i;
    // Emptiness is the pre-push state, so a response can never retire its own grant cycle.
    assign do_pop    = obi_rvalid_i && !fifo_empty;
    assign do_push   = granted && (!fifo_full || do_pop);
    assign violation = (obi_rvalid_i && fifo_empty) || (granted && fifo_full && !do_pop);

    cv32e41s_rvfi_obi_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (do_push),
        .push_data_i (push_data),
        .pop_i       (do_pop),
        .pop_data_o  (pop_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (outstanding_o)
    );

    always_comb begin
        off      = pop_data.addr[1:0];
        be_al    = pop_data.be >> off;
        rdata_al = obi_ror32(obi_rdata_i, off) & obi_be_expand(be_al);
        wdata_al = obi_ror32(pop_data.wdata, off);

        resp_addr_d  = resp_addr_q;
        resp_we_d    = resp_we_q;
        resp_be_d    = resp_be_q;
        resp_rdata_d = resp_rdata_q;
        resp_wdata_d = resp_wdata_q;
        resp_err_d   = resp_err_q;
        if (do_pop) begin
            resp_addr_d  = pop_data.addr;
            resp_we_d    = pop_data.we;
            resp_be_d    = be_al;
            resp_rdata_d = pop_data.we ? 32'h0 : rdata_al;
            resp_wdata_d = pop_data.we ? wdata_al : 32'h0;
            resp_err_d   = obi_err_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_q   <= 1'b0;
            resp_addr_q    <= '0;
            resp_we_q      <= 1'b0;
            resp_be_q      <= '0;
            resp_rdata_q   <= '0;
            resp_wdata_q   <= '0;
            resp_err_q     <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            resp_valid_q   <= do_pop;
            resp_addr_q    <= resp_addr_d;
            resp_we_q      <= resp_we_d;
            resp_be_q      <= resp_be_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_wdata_q   <= resp_wdata_d;
            resp_err_q     <= resp_err_d;
            protocol_err_q <= protocol_err_q | violation;
        end
    end

    assign resp_valid_o   = resp_valid_q;
    assign resp_addr_o    = resp_addr_q;
    assign resp_we_o      = resp_we_q;
    assign resp_be_o      = resp_be_q;
    assign resp_rdata_o   = resp_rdata_q;
    assign resp_wdata_o   = resp_wdata_q;
    assign resp_err_o     = resp_err_q;
    assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_cv32e41s_rvfi_data_obi_resp.sv
// tb/tb_cv32e41s_rvfi_data_obi_resp.sv - scoreboard bench for the RVFI data OBI response tracker
module tb_cv32e41s_rvfi_data_obi_resp;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        obi_req_i, obi_gnt_i, obi_we_i, obi_rvalid_i, obi_err_i;
    logic [31:0] obi_addr_i, obi_wdata_i, obi_rdata_i;
    logic [3:0]  obi_be_i;
    logic        resp_valid_o, resp_we_o, resp_err_o, protocol_err_o;
    logic [31:0] resp_addr_o, resp_rdata_o, resp_wdata_o;
    logic [3:0]  resp_be_o;
    logic [1:0]  outstanding_o;

    cv32e41s_rvfi_data_obi_resp #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .obi_req_i      (obi_req_i),
        .obi_gnt_i      (obi_gnt_i),
        .obi_addr_i     (obi_addr_i),
        .obi_we_i       (obi_we_i),
        .obi_be_i       (obi_be_i),
        .obi_wdata_i    (obi_wdata_i),
        .obi_rvalid_i   (obi_rvalid_i),
        .obi_rdata_i    (obi_rdata_i),
        .obi_err_i      (obi_err_i),
        .resp_valid_o   (resp_valid_o),
        .resp_addr_o    (resp_addr_o),
        .resp_we_o      (resp_we_o),
        .resp_be_o      (resp_be_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_wdata_o   (resp_wdata_o),
        .resp_err_o     (resp_err_o),
        .outstanding_o  (outstanding_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_act, mon_exp;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                input logic [31:0] rdata, input logic [31:0] wdata, input logic err);
        exp_t e;
        e = '{addr: addr, we: we, be: be, rdata: rdata, wdata: wdata, err: err};
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every presented record is popped against the scoreboard in order.
    always @(negedge clk) begin
        if (resp_valid_o === 1'b1) begin
            mon_act = '{addr: resp_addr_o, we: resp_we_o, be: resp_be_o,
                        rdata: resp_rdata_o, wdata: resp_wdata_o, err: resp_err_o};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_record actual=%h required=none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL record actual=%h required=%h", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata);
        obi_req_i = 1'b1; obi_gnt_i = 1'b1;
        obi_addr_i = addr; obi_we_i = we; obi_be_i = be; obi_wdata_i = wdata;
        tick();
        obi_req_i = 1'b0; obi_gnt_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err, input exp_t e);
        exp_q.push_back(e);
        obi_rvalid_i = 1'b1; obi_rdata_i = rdata; obi_err_i = err;
        tick();
        obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
        check("latency_valid", {127'h0, resp_valid_o}, 128'h1);
        tick();
        check("pulse_low", {127'h0, resp_valid_o}, 128'h0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {22'h0, resp_valid_o, resp_addr_o, resp_we_o, resp_be_o, resp_rdata_o,
                     resp_wdata_o, resp_err_o, outstanding_o, protocol_err_o}, 128'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        obi_req_i = 0; obi_gnt_i = 0; obi_we_i = 0; obi_rvalid_i = 0; obi_err_i = 0;
        obi_addr_i = 0; obi_wdata_i = 0; obi_rdata_i = 0; obi_be_i = 0;
        tick(); tick();
        rst_n = 1'b1;
        check_all_zero("reset_state");

        grant(32'h1000, 1'b0, 4'hF, 32'h12345678);
        respond(32'hDEADBEEF, 1'b0, mk(32'h1000, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0));

        grant(32'h1003, 1'b0, 4'h8, 32'h0);
        respond(32'hAB000000, 1'b0, mk(32'h1003, 1'b0, 4'h1, 32'h000000AB, 32'h0, 1'b0));

        grant(32'h2002, 1'b1, 4'hC, 32'h55660000);
        respond(32'hFFFFFFFF, 1'b0, mk(32'h2002, 1'b1, 4'h3, 32'h0, 32'h00005566, 1'b0));

        grant(32'h3001, 1'b0, 4'h6, 32'h0);
        respond(32'hFF_CAFE_EE, 1'b0, mk(32'h3001, 1'b0, 4'h3, 32'h0000CAFE, 32'h0, 1'b0));

        // Pipelined: A, B, then C granted alongside A's response.
        grant(32'h10, 1'b0, 4'hF, 32'h0);
        check("outst_1", {126'h0, outstanding_o}, 128'd1);
        grant(32'h14, 1'b0, 4'hF, 32'h0);
        check("outst_2", {126'h0, outstanding_o}, 128'd2);
        exp_q.push_back(mk(32'h10, 1'b0, 4'hF, 32'h11, 32'h0, 1'b0));
        obi_req_i = 1'b1; obi_gnt_i = 1'b1; obi_addr_i = 32'h18; obi_we_i = 1'b0; obi_be_i = 4'hF;
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'h11;
        tick();
        obi_req_i = 1'b0; obi_gnt_i = 1'b0;
        check("outst_2b", {126'h0, outstanding_o}, 128'd2);
        exp_q.push_back(mk(32'h14, 1'b0, 4'hF, 32'h22, 32'h0, 1'b0));
        obi_rdata_i = 32'h22;
        tick();
        check("outst_1b", {126'h0, outstanding_o}, 128'd1);
        exp_q.push_back(mk(32'h18, 1'b0, 4'hF, 32'h33, 32'h0, 1'b0));
        obi_rdata_i = 32'h33;
        tick();
        obi_rvalid_i = 1'b0;
        check("outst_0", {126'h0, outstanding_o}, 128'd0);
        tick();
        check("pipe_pulse_end", {127'h0, resp_valid_o}, 128'h0);

        grant(32'h20, 1'b0, 4'hF, 32'h0);
        respond(32'h0, 1'b1, mk(32'h20, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1));
        grant(32'h24, 1'b0, 4'hF, 32'h0);
        respond(32'hAABBCCDD, 1'b1, mk(32'h24, 1'b0, 4'hF, 32'hAABBCCDD, 32'h0, 1'b1));
        check("perr_after_err", {127'h0, protocol_err_o}, 128'h0);

        // rvalid with nothing outstanding.
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'h99;
        tick();
        obi_rvalid_i = 1'b0;
        tick();
        check("stray_no_record", {127'h0, resp_valid_o}, 128'h0);
        check("stray_perr", {127'h0, protocol_err_o}, 128'h1);
        tick(); tick();
        check("perr_sticky", {127'h0, protocol_err_o}, 128'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("reset_clears");

        // Overflow: third grant with tracker full is dropped.
        obi_req_i = 1'b1; obi_gnt_i = 1'b1; obi_we_i = 1'b0; obi_be_i = 4'hF;
        obi_addr_i = 32'h40; tick();
        obi_addr_i = 32'h44; tick();
        check("perr_before_ovf", {127'h0, protocol_err_o}, 128'h0);
        obi_addr_i = 32'h48; tick();
        obi_req_i = 1'b0; obi_gnt_i = 1'b0;
        check("ovf_saturate", {126'h0, outstanding_o}, 128'd2);
        check("ovf_perr", {127'h0, protocol_err_o}, 128'h1);
        respond(32'h1, 1'b0, mk(32'h40, 1'b0, 4'hF, 32'h1, 32'h0, 1'b0));
        respond(32'h2, 1'b0, mk(32'h44, 1'b0, 4'hF, 32'h2, 32'h0, 1'b0));
        check("ovf_drained", {126'h0, outstanding_o}, 128'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("records_drained", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e41s_rvfi_data_obi_resp.md
Name: cv32e41s_rvfi_data_obi_resp

Overview:
- Response-side companion for RVFI data tracking. Sits on the data OBI bus between the LSU and the bus.
- Records every granted request (address, byte enables, write flag, write data) in an in-order tracker and pairs it with the matching rvalid response.
- For each completed transaction it emits one registered record. Load data is right-aligned to bit 0 and masked to the enabled bytes; bus error status is included.
- Also checks basic OBI response ordering and flags violations on a sticky error output.

Parameters:
- DEPTH, 2, maximum outstanding (granted, not yet responded) transactions; power of two, >= 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous active-low.
- obi_req_i  input  1  data OBI req.
- obi_gnt_i  input  1  data OBI gnt.
- obi_addr_i  input  32  request address.
- obi_we_i  input  1  request write enable.
- obi_be_i  input  4  request byte enables (word-relative).
- obi_wdata_i  input  32  request write data (bus lane positions).
- obi_rvalid_i  input  1  response valid.
- obi_rdata_i  input  32  response read data (bus lane positions).
- obi_err_i  input  1  response bus error.
- resp_valid_o  output  1  completed-transaction record valid, 1-cycle pulse.
- resp_addr_o  output  32  address of completed transaction.
- resp_we_o  output  1  write flag.
- resp_be_o  output  4  right-aligned byte mask: obi_be >> addr[1:0].
- resp_rdata_o  output  32  aligned, masked load data; 0 for writes.
- resp_wdata_o  output  32  write data rotated right by 8*addr[1:0]; 0 for loads.
- resp_err_o  output  1  obi_err_i of the response.
- outstanding_o  output  $clog2(DEPTH+1)  current outstanding count.
- protocol_err_o  output  1  sticky protocol-violation flag.

Behaviour:
- Reset: when rst_n=0 at a rising edge, clear all state.
  - Count 0, read/write pointers 0.
  - All resp_* outputs 0; protocol_err_o 0.
- Push: on a cycle with obi_req_i && obi_gnt_i, store {addr, we, be, wdata} at the write pointer.
  - Write pointer wraps modulo DEPTH; count +1.
- Pop: on a cycle with obi_rvalid_i and count>0, read the entry at the read pointer.
  - Read pointer wraps; count -1.
  - In the next cycle, register and drive the record: resp_valid_o=1 for exactly one cycle.
  - Latency is exactly 1 cycle from rvalid to resp_valid_o.
- Push and pop in the same cycle: both happen and count is unchanged. The pop always uses the oldest entry, never the one being pushed.
- Alignment for record fields:
  - off = addr[1:0].
  - mask = byte-expand(be >> off).
  - resp_rdata_o = (ror(rdata, 8*off)) & mask, for loads.
  - resp_wdata_o = ror(wdata, 8*off), for writes.
  - The rotation is a 64-bit concatenate-then-shift, keeping the low 32 bits.
- Bus error: resp_err_o copies obi_err_i. On an error, resp_rdata_o is still computed as above (no special zeroing).
- Protocol violations: each sets protocol_err_o=1, which holds until reset.
  - rvalid with count==0: no pop, no record.
  - Grant when count==DEPTH and no simultaneous pop: the request is dropped and count saturates at DEPTH.
- resp_* fields hold their last value when resp_valid_o=0.
- A response is never produced in the same cycle as its grant; this is guaranteed by count==0 checking the pre-push count.

Decomposition:
- Put typedef rvfi_obi_trans_t {addr, we, be, wdata} and function obi_ror32(data, off) in cv32e41s_rvfi_pkg.
- Sub-module cv32e41s_rvfi_obi_fifo: parametric DEPTH in-order FIFO with count, push/pop, and full/empty outputs.
- The top level does the alignment, the output register, and the violation checks.

Test Plan:
- Load word at 0x1000, be=4'hF, rdata=0xDEADBEEF one cycle after gnt -> resp_valid_o one cycle later; resp_rdata_o=0xDEADBEEF, resp_be_o=4'hF, resp_err_o=0.
- Byte load at 0x1003, be=4'h8, rdata=0xAB000000 -> resp_rdata_o=0x000000AB, resp_be_o=4'h1.
- Halfword store at 0x2002, be=4'hC, wdata=0x55660000 -> resp_wdata_o=0x00005566, resp_we_o=1, resp_rdata_o=0.
- Pipelined access, DEPTH=2: grant A(0x10) and B(0x14) back-to-back, then respond rdata 0x11 and 0x22, with a third grant in the same cycle as the first rvalid.
  - Records come out in order A=0x11, B=0x22.
  - outstanding_o goes 1,2,2,1,0.
- Error response: word load with obi_err_i=1, rdata=0 -> resp_err_o=1, resp_rdata_o=0; protocol_err_o stays 0.
- Violations: rvalid with nothing outstanding -> no resp_valid_o and protocol_err_o=1, held until rst_n=0 for one clock, after which every output is 0.
